pipe_stage_reg: RTL

- Parametrised pipeline stage register, the next generation of the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle of configurable width.
- Uses valid/ready handshake with a 2-entry skid buffer, so throughput stays at full rate with a registered ready.
- Adds flush with bubble insertion; a bubble forces control to zero so downstream never sees a stale RegWrite or MemWrite.

---
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline stage register with valid/ready handshake, a
//               2-entry skid buffer, flush with bubble insertion, and an
//               optional stall counter enabled by macro PIPE_STAGE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                  CTRL_W      = 8,
    parameter int                  DATA_W      = 128,
    parameter logic [CTRL_W-1:0]   CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
`ifdef PIPE_STAGE_STATS_EN
    output logic [31:0]       stall_cnt_o,
`endif
    output logic [1:0]        occ_o
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_push;
    logic w_pop;

    assign in_ready_o  = (r_state != TWO);
    assign out_valid_o = (r_state != EMPTY);
    assign occ_o       = r_state;
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    assign out_ctrl_o  = out_valid_o ? r_main_ctrl : CTRL_BUBBLE;
    assign out_data_o  = r_main_data;

    // Data registers load only on push, so X on idle inputs stays out of state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush_i) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state     <= ONE;
                        r_main_ctrl <= in_ctrl_i;
                        r_main_data <= in_data_i;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_main_ctrl <= in_ctrl_i;
                        r_main_data <= in_data_i;
                    end else if (w_push) begin
                        r_state     <= TWO;
                        r_skid_ctrl <= in_ctrl_i;
                        r_skid_data <= in_data_i;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_state     <= ONE;
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (out_valid_o && !out_ready_i && !flush_i &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
